// File: rtl/bi_mem_tp_wm_arb.sv
// bi_mem_tp_wm_arb
//
// Purpose:
//   Places a bank of PORTS requesters in front of a two-port memory with a write mask.
//   The memory has one write port and one read port, and the read port has one cycle
//   of latency. Writes and reads each have their own round-robin arbiter. Each grant
//   is a combinational function of the requests in the same cycle. The arbiters steer
//   the winner's fields straight to the memory and never store request fields. Read
//   data comes back one cycle after the grant. It appears on a shared bus, and a
//   one-hot valid vector marks which requester it belongs to.
//
// Configuration macro:
//   BI_MEM_ARB_COLLISION_STALL_EN
//     Defined: if both winners target the same address in the same cycle, the read
//     loses that cycle and its pointer holds. The read is served on the following
//     cycle and so returns the freshly written data.
//     Undefined: there is no collision check.
//
// Ports (requester i owns slice i of each packed array):
//   clk_i            - clock; all state changes on the rising edge
//   rst_ni           - synchronous active-low reset; also forces grants/enables low
//   wrReq_i/wrAddr_i/wrMask_i/wrData_i - write requests and their fields
//   wrGnt_o          - write grant, one-hot or zero
//   rdReq_i/rdAddr_i - read requests and their addresses
//   rdGnt_o          - read grant, one-hot or zero
//   rdValid_o        - read data valid, one-hot or zero, one cycle after the grant
//   rdData_o         - shared read data, zero when nothing is valid
//   memRead*/memWrite* - memory-side read and masked-write ports

module bi_mem_tp_wm_arb #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned HEIGHT = 16,
    parameter int unsigned MASK   = 4,
    parameter int unsigned PORTS  = 2,
    localparam int unsigned AW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    input  logic [PORTS-1:0]       wrReq_i,
    input  logic [PORTS*AW-1:0]    wrAddr_i,
    input  logic [PORTS*MASK-1:0]  wrMask_i,
    input  logic [PORTS*WIDTH-1:0] wrData_i,
    output logic [PORTS-1:0]       wrGnt_o,

    input  logic [PORTS-1:0]       rdReq_i,
    input  logic [PORTS*AW-1:0]    rdAddr_i,
    output logic [PORTS-1:0]       rdGnt_o,
    output logic [PORTS-1:0]       rdValid_o,
    output logic [WIDTH-1:0]       rdData_o,

    output logic                   memReadEnable_o,
    output logic [AW-1:0]          memReadAddr_o,
    input  logic [WIDTH-1:0]       memReadData_i,

    output logic                   memWriteEnable_o,
    output logic [MASK-1:0]        memWriteMask_o,
    output logic [AW-1:0]          memWriteAddr_o,
    output logic [WIDTH-1:0]       memWriteData_o
);

    localparam int unsigned PW = (PORTS > 1) ? $clog2(PORTS) : 1;

    // Selects the requester nearest the pointer, counting upward from the pointer
    // itself and wrapping at PORTS. The distance is measured from the pointer, so the
    // smallest distance among active requests wins.
    function automatic logic [PORTS-1:0] rr_pick(input logic [PORTS-1:0] req,
                                                 input logic [PW-1:0]    ptr);
        logic [PORTS-1:0] gnt;
        int unsigned      best_off;
        int unsigned      best_idx;
        int unsigned      off;
        logic             found;
        gnt      = '0;
        best_off = PORTS;
        best_idx = 0;
        found    = 1'b0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            off = (PORTS + i - 32'(ptr)) % PORTS;
            if (req[i] && (off < best_off)) begin
                best_off = off;
                best_idx = i;
                found    = 1'b1;
            end
        end
        for (int unsigned i = 0; i < PORTS; i++) begin
            gnt[i] = found && (i == best_idx);
        end
        return gnt;
    endfunction

    // The pointer moves to just past the winner. It holds when nobody is granted.
    function automatic logic [PW-1:0] rr_next(input logic [PORTS-1:0] gnt,
                                              input logic [PW-1:0]    ptr);
        logic [PW-1:0] nxt;
        nxt = ptr;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (gnt[i]) begin
                nxt = PW'((i + 1) % PORTS);
            end
        end
        return nxt;
    endfunction

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PORTS-1:0] rd_valid_q;

    logic [PORTS-1:0] wr_gnt;
    logic [PORTS-1:0] rd_cand;
    logic [PORTS-1:0] rd_gnt;
    logic [AW-1:0]    wr_addr_win;
    logic [MASK-1:0]  wr_mask_win;
    logic [WIDTH-1:0] wr_data_win;
    logic [AW-1:0]    rd_addr_cand;
    logic             collide;

    // Arbitration and winner muxing. Each grant is one-hot, so OR-ing the selected
    // slices gives exactly the winner's fields.
    always_comb begin
        wr_gnt       = rst_ni ? rr_pick(wrReq_i, wr_ptr_q) : '0;
        rd_cand      = rst_ni ? rr_pick(rdReq_i, rd_ptr_q) : '0;
        wr_addr_win  = '0;
        wr_mask_win  = '0;
        wr_data_win  = '0;
        rd_addr_cand = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (wr_gnt[i]) begin
                wr_addr_win = wr_addr_win | wrAddr_i[i*AW +: AW];
                wr_mask_win = wr_mask_win | wrMask_i[i*MASK +: MASK];
                wr_data_win = wr_data_win | wrData_i[i*WIDTH +: WIDTH];
            end
            if (rd_cand[i]) begin
                rd_addr_cand = rd_addr_cand | rdAddr_i[i*AW +: AW];
            end
        end
`ifdef BI_MEM_ARB_COLLISION_STALL_EN
        // The write goes first. The read retries next cycle and sees the new data.
        collide = (|wr_gnt) && (|rd_cand) && (rd_addr_cand == wr_addr_win);
`else
        collide = 1'b0;
`endif
        rd_gnt   = collide ? '0 : rd_cand;
        wr_ptr_d = rr_next(wr_gnt, wr_ptr_q);
        // A suppressed read sees no grant here, so its pointer stays put.
        rd_ptr_d = rr_next(rd_gnt, rd_ptr_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_gnt;
        end
    end

    always_comb begin
        wrGnt_o          = wr_gnt;
        rdGnt_o          = rd_gnt;

        memWriteEnable_o = |wr_gnt;
        memWriteAddr_o   = wr_addr_win;
        memWriteMask_o   = wr_mask_win;
        memWriteData_o   = wr_data_win;

        memReadEnable_o  = |rd_gnt;
        memReadAddr_o    = (|rd_gnt) ? rd_addr_cand : '0;

        // Gate with reset as well. A read granted just before reset asserts must not
        // show valid while reset is held.
        rdValid_o        = rst_ni ? rd_valid_q : '0;
        rdData_o         = (|rdValid_o) ? memReadData_i : '0;
    end

endmodule
